// File: rtl/uart_tx_arbiter.sv
// Two-source byte arbiter in front of a UART transmitter.
// Round-robin grant with per-grant burst limit and combinational byte pass-through.
module uart_tx_arbiter #(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic       clk48,
  input  logic       rstn,
  input  logic       en,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [1:0] grant,
  output logic       busy
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] G0   = 2'b01;
  localparam logic [1:0] G1   = 2'b10;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  logic [1:0] state_reg, state_next;
  logic       lsp_reg, lsp_next;
  logic [7:0] bcnt_reg, bcnt_next;

  logic       hold_valid;
  logic       hold_last;
  logic       other_valid;
  logic       xfer;
  logic       release_now;

  // Holder-relative views of the two request ports.
  always_comb begin
    hold_valid  = 1'b0;
    hold_last   = 1'b0;
    other_valid = 1'b0;
    case (state_reg)
      G0: begin
        hold_valid  = s0_valid;
        hold_last   = s0_last;
        other_valid = s1_valid;
      end
      G1: begin
        hold_valid  = s1_valid;
        hold_last   = s1_last;
        other_valid = s0_valid;
      end
      default: ;
    endcase
  end

  assign xfer        = (state_reg != IDLE) && hold_valid && m_ready;
  assign release_now = xfer && (hold_last || (bcnt_reg == LAST_BEAT));

  always_comb begin
    state_next = state_reg;
    bcnt_next  = bcnt_reg;
    case (state_reg)
      IDLE: begin
        bcnt_next = 8'd0;
        if (en) begin
          if (s0_valid && (!s1_valid || lsp_reg)) begin
            state_next = G0;
          end else if (s1_valid) begin
            state_next = G1;
          end
        end
      end
      G0, G1: begin
        if (release_now) begin
          bcnt_next = 8'd0;
          // The holder's valid is necessarily high on the releasing beat, so an
          // immediate re-grant is only taken when its packet is still open.
          if (other_valid && en) begin
            state_next = (state_reg == G0) ? G1 : G0;
          end else if (!hold_last && en) begin
            state_next = state_reg;
          end else begin
            state_next = IDLE;
          end
        end else if (xfer) begin
          bcnt_next = bcnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        bcnt_next  = 8'd0;
      end
    endcase
  end

  always_comb begin
    lsp_next = lsp_reg;
    if (state_next == G0) begin
      lsp_next = 1'b0;
    end else if (state_next == G1) begin
      lsp_next = 1'b1;
    end
  end

  always_ff @(posedge clk48 or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      lsp_reg   <= 1'b1;
      bcnt_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      lsp_reg   <= lsp_next;
      bcnt_reg  <= bcnt_next;
    end
  end

  assign grant = {state_reg == G1, state_reg == G0};
  assign busy  = (state_reg != IDLE);

  // Zero-latency byte path from the current holder to the transmitter.
  always_comb begin
    m_data   = 8'h00;
    m_valid  = 1'b0;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    case (state_reg)
      G0: begin
        m_data   = s0_data;
        m_valid  = s0_valid;
        s0_ready = m_ready;
      end
      G1: begin
        m_data   = s1_data;
        m_valid  = s1_valid;
        s1_ready = m_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and constrained-random bench for uart_tx_arbiter (MAX_BURST = 16).
module tb_uart_tx_arbiter;

  localparam int MB = 16;

  logic       clk48 = 1'b0;
  logic       rstn  = 1'b1;
  logic       en    = 1'b1;
  logic [7:0] s0_data = 8'h00, s1_data = 8'h00;
  logic       s0_valid = 1'b0, s1_valid = 1'b0;
  logic       s0_last = 1'b0, s1_last = 1'b0;
  logic       m_ready = 1'b0;
  logic       s0_ready, s1_ready, m_valid, busy;
  logic [7:0] m_data;
  logic [1:0] grant;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.MAX_BURST(MB)) dut (
    .clk48(clk48), .rstn(rstn), .en(en),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk48 = ~clk48;

  task automatic tick;
    @(posedge clk48);
    #1;
  endtask

  task automatic clear_inputs;
    en = 1'b1; m_ready = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0; s0_last = 1'b0; s1_last = 1'b0;
    s0_data = 8'h00; s1_data = 8'h00;
  endtask

  task automatic do_reset;
    clear_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    s0_valid = 1'b1; s1_valid = 1'b1; m_ready = 1'b1;
    tick();
    tick();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", grant); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h expected 00", m_data); end
    n_checks++; if ({s1_ready, s0_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", {s1_ready, s0_ready}); end
    $display("test_reset done");
  endtask

  task automatic test_alternate_burst;
    int c0 = 0;
    int c1 = 0;
    logic [1:0] eg;
    logic [7:0] ed;
    do_reset();
    s0_valid = 1'b1; s1_valid = 1'b1; m_ready = 1'b1;
    #1;
    n_checks++; if (m_valid !== 1'b0 || grant !== 2'b00) begin n_fail++; $display("FAIL alt_idle: got grant=%b m_valid=%b expected 00/0", grant, m_valid); end
    tick();
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < MB; k++) begin
        s0_data = 8'(c0);
        s1_data = 8'(8'h80 + c1);
        #1;
        eg = (b % 2 == 0) ? 2'b01 : 2'b10;
        ed = (b % 2 == 0) ? 8'(c0) : 8'(8'h80 + c1);
        n_checks++; if (grant !== eg) begin n_fail++; $display("FAIL alt_grant b%0d k%0d: got %b expected %b", b, k, grant, eg); end
        n_checks++; if (m_data !== ed) begin n_fail++; $display("FAIL alt_data b%0d k%0d: got %h expected %h", b, k, m_data, ed); end
        if (b % 2 == 0) c0++; else c1++;
        tick();
      end
      $display("burst %0d: %0d bytes", b, MB);
    end
  endtask

  task automatic test_packet_end;
    do_reset();
    s0_valid = 1'b1; m_ready = 1'b1; s0_data = 8'hA0;
    #1;
    n_checks++; if (s0_ready !== 1'b0) begin n_fail++; $display("FAIL pkt_idle_ready: got %b expected 0", s0_ready); end
    tick();
    for (int i = 0; i < 3; i++) begin
      s0_data = 8'(8'hA0 + i);
      s0_last = (i == 2);
      #1;
      n_checks++; if (grant !== 2'b01 || m_data !== 8'(8'hA0 + i) || s0_ready !== 1'b1) begin
        n_fail++; $display("FAIL pkt_byte%0d: got grant=%b data=%h ready=%b expected 01/%h/1", i, grant, m_data, s0_ready, 8'(8'hA0 + i));
      end
      tick();
    end
    s0_valid = 1'b0; s0_last = 1'b0;
    #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL pkt_release_grant: got %b expected 00", grant); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pkt_release_busy: got %b expected 0", busy); end
    s0_valid = 1'b1; s1_valid = 1'b1;
    tick();
    n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL pkt_lsp_tie: got %b expected 10", grant); end
    $display("test_packet_end done");
  endtask

  task automatic test_stall;
    do_reset();
    s0_valid = 1'b1; s1_valid = 1'b1; s0_data = 8'h5A; s1_data = 8'hC3; m_ready = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL stall_grant c%0d: got %b expected 01", i, grant); end
      n_checks++; if (m_data !== 8'h5A || m_valid !== 1'b1) begin n_fail++; $display("FAIL stall_data c%0d: got %h/%b expected 5a/1", i, m_data, m_valid); end
      n_checks++; if (s1_ready !== 1'b0 || s0_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready c%0d: got %b%b expected 00", i, s1_ready, s0_ready); end
      tick();
    end
    m_ready = 1'b1; s0_last = 1'b1;
    #1;
    n_checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin n_fail++; $display("FAIL stall_resume_ready: got %b%b expected 01", s1_ready, s0_ready); end
    tick();
    s0_last = 1'b0; s0_valid = 1'b0;
    #1;
    n_checks++; if (grant !== 2'b10 || m_data !== 8'hC3) begin n_fail++; $display("FAIL stall_handover: got %b/%h expected 10/c3", grant, m_data); end
    $display("test_stall done");
  endtask

  task automatic test_en_drop;
    do_reset();
    s1_valid = 1'b1; m_ready = 1'b1; s1_data = 8'h10;
    tick();
    for (int i = 0; i < 5; i++) begin
      s1_data = 8'(8'h10 + i);
      s1_last = (i == 4);
      if (i == 2) begin
        en = 1'b0; s0_valid = 1'b1; s0_data = 8'hEE;
      end
      #1;
      n_checks++; if (grant !== 2'b10 || m_data !== 8'(8'h10 + i)) begin
        n_fail++; $display("FAIL en_byte%0d: got %b/%h expected 10/%h", i, grant, m_data, 8'(8'h10 + i));
      end
      tick();
    end
    s1_valid = 1'b0; s1_last = 1'b0;
    #1;
    n_checks++; if (grant !== 2'b00 || s0_ready !== 1'b0) begin n_fail++; $display("FAIL en_release: got %b/%b expected 00/0", grant, s0_ready); end
    tick();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL en_hold_idle: got %b expected 00", grant); end
    en = 1'b1;
    tick();
    n_checks++; if (grant !== 2'b01 || m_data !== 8'hEE) begin n_fail++; $display("FAIL en_regrant: got %b/%h expected 01/ee", grant, m_data); end
    $display("test_en_drop done");
  endtask

  task automatic test_async_reset;
    do_reset();
    s0_valid = 1'b1; m_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      s0_data = 8'(8'h30 + i);
      tick();
    end
    s0_data = 8'h33;
    #1;
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL arst_pre: got %b expected 01", grant); end
    rstn = 1'b0;
    #1;
    n_checks++; if (grant !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_immediate: got %b/%b expected 00/0", grant, busy); end
    n_checks++; if (m_valid !== 1'b0 || s0_ready !== 1'b0) begin n_fail++; $display("FAIL arst_outputs: got %b/%b expected 0/0", m_valid, s0_ready); end
    s1_valid = 1'b1;
    tick();
    rstn = 1'b1;
    #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL arst_release: got %b expected 00", grant); end
    tick();
    n_checks++; if (grant !== 2'b01 || m_data !== 8'h33) begin n_fail++; $display("FAIL arst_first_grant: got %b/%h expected 01/33", grant, m_data); end
    $display("test_async_reset done");
  endtask

  task automatic test_random;
    int c0 = 0;
    int c1 = 0;
    int run_cnt = 0;
    int total = 0;
    logic lsp = 1'b1;
    logic [1:0] g, expg;
    logic chk, xfer, rel, other_v, own_last;
    do_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      en       = ($urandom_range(0, 15) != 0);
      m_ready  = ($urandom_range(0, 3) != 0);
      s0_valid = ($urandom_range(0, 3) != 0);
      s1_valid = ($urandom_range(0, 3) != 0);
      s0_last  = ($urandom_range(0, 5) == 0);
      s1_last  = ($urandom_range(0, 5) == 0);
      s0_data  = 8'(c0);
      s1_data  = 8'(c1 ^ 8'hA5);
      #1;
      g = grant;
      chk = 1'b0; expg = 2'b00; rel = 1'b0;
      xfer = m_valid && m_ready;
      n_checks++; if (g === 2'b11 || busy !== (g != 2'b00)) begin n_fail++; $display("FAIL rnd_onehot c%0d: got grant=%b busy=%b", cyc, g, busy); end
      if (g == 2'b00) begin
        n_checks++; if (m_valid !== 1'b0 || m_data !== 8'h00 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
          n_fail++; $display("FAIL rnd_idle_out c%0d: got v=%b d=%h r=%b%b expected 0/00/00", cyc, m_valid, m_data, s1_ready, s0_ready);
        end
        chk = 1'b1;
        if (en && (s0_valid || s1_valid)) expg = (s0_valid && (!s1_valid || lsp)) ? 2'b01 : 2'b10;
      end else begin
        other_v  = (g == 2'b01) ? s1_valid : s0_valid;
        own_last = (g == 2'b01) ? s0_last : s1_last;
        if (xfer) begin
          total++;
          if (g == 2'b01) begin
            n_checks++; if (m_data !== 8'(c0) || s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
              n_fail++; $display("FAIL rnd_s0_byte c%0d: got %h r=%b%b expected %h r=01", cyc, m_data, s1_ready, s0_ready, 8'(c0));
            end
            c0++;
          end else begin
            n_checks++; if (m_data !== 8'(c1 ^ 8'hA5) || s1_ready !== 1'b1 || s0_ready !== 1'b0) begin
              n_fail++; $display("FAIL rnd_s1_byte c%0d: got %h r=%b%b expected %h r=10", cyc, m_data, s1_ready, s0_ready, 8'(c1 ^ 8'hA5));
            end
            c1++;
          end
          n_checks++; if (run_cnt >= MB) begin n_fail++; $display("FAIL rnd_burst_len c%0d: got %0d beats expected <= %0d", cyc, run_cnt + 1, MB); end
          run_cnt++;
          rel = own_last || (run_cnt == MB);
          if (!rel) begin
            chk = 1'b1; expg = g;
          end else if (other_v && en) begin
            chk = 1'b1; expg = {g[0], g[1]};
          end else if (!en) begin
            chk = 1'b1; expg = 2'b00;
          end
        end else begin
          chk = 1'b1; expg = g;
        end
      end
      tick();
      if (chk) begin
        n_checks++; if (grant !== expg) begin n_fail++; $display("FAIL rnd_next_grant c%0d: got %b expected %b (from %b xfer=%b)", cyc, grant, expg, g, xfer); end
      end
      if (grant != g || rel) run_cnt = 0;
      if (grant == 2'b01) lsp = 1'b0;
      else if (grant == 2'b10) lsp = 1'b1;
    end
    n_checks++; if (total < 2000) begin n_fail++; $display("FAIL rnd_progress: got %0d transfers expected >= 2000", total); end
    $display("test_random: %0d transfers, s0=%0d s1=%0d", total, c0, c1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    #1;
    test_reset();
    test_alternate_burst();
    test_packet_end();
    test_stall();
    test_en_drop();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16, giving max bytes per grant before forced release (legal 1..255).
REQ-002 SHALL have port clk48  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port en  input  1  arbitration enable; low blocks new grants only.
REQ-005 SHALL have ports s0_data/s1_data  input  8  requester byte.
REQ-006 SHALL have ports s0_valid/s1_valid  input  1  requester byte valid.
REQ-007 SHALL have ports s0_last/s1_last  input  1  byte ends requester packet.
REQ-008 SHALL have ports s0_ready/s1_ready  output  1  byte accepted this cycle when valid&ready.
REQ-009 SHALL have port m_data  output  8  byte to UART transmitter.
REQ-010 SHALL have port m_valid  output  1  m_data valid.
REQ-011 SHALL have port m_ready  input  1  UART transmitter accepts byte.
REQ-012 SHALL have port grant  output  2  one-hot current owner (bit0=s0, bit1=s1, 00=none).
REQ-013 SHALL have port busy  output  1  high while grant != 00.

Function
REQ-014 SHALL implement FSM states IDLE, G0, G1; grant = {state==G1, state==G0}; grant and state registered.
REQ-015 SHALL keep a registered last-served pointer lsp (0 or 1) updated on every entry to G0 (lsp=0) or G1 (lsp=1).
REQ-016 IDLE, en=1: only s0_valid -> G0; only s1_valid -> G1; both -> the source != lsp; neither or en=0 -> stay IDLE.
REQ-017 Grant takes effect cycle after request seen in IDLE (1-cycle arbitration latency); no byte transfers in IDLE.
REQ-018 In Gx: m_data=sx_data, m_valid=sx_valid, sx_ready=m_ready, other s_ready=0 (combinational pass-through, zero added byte latency).
REQ-019 In IDLE: m_valid=0, m_data=8'h00, s0_ready=s1_ready=0.
REQ-020 Transfer = m_valid&m_ready in Gx; beat counter bcnt (8 bits) increments per transfer, cleared on every grant change.
REQ-021 Release in Gx SHALL occur on a transfer with sx_last=1 or with bcnt==MAX_BURST-1.
REQ-022 On release, next state: other source valid and en=1 -> other's G; else own source valid and en=1 -> own G again (bcnt cleared); else IDLE.
REQ-023 No release without a transfer: holder stalls (valid low or m_ready low) keep grant indefinitely.
REQ-024 en deassert mid-burst SHALL NOT truncate; burst continues to release, then REQ-022 with en=0 -> IDLE.
REQ-025 Simultaneous release and other-source new valid SHALL hand over with no idle cycle.
REQ-026 Byte order within a source preserved; no byte dropped or duplicated; at most one transfer per cycle.
REQ-027 m_data/m_valid SHALL be stable-compatible: arbiter never changes grant while m_valid=1 and m_ready=0.

Reset
REQ-028 On rstn low, asynchronously: state=IDLE, grant=00, busy=0, lsp=1, bcnt=0; hence m_valid=0, s0_ready=s1_ready=0.
REQ-029 Reset mid-burst SHALL abandon the burst; after rstn rises, first arbitration is fresh, s0 wins a tie.
REQ-030 First arbitration SHALL occur on the first clk48 edge after rstn deassertion.

Verification
REQ-031 Reset, both valid every cycle, m_ready=1, no last, MAX_BURST=16 -> grant 01 for 16 bytes, then 10 for 16 bytes, alternating, no idle cycle between.
REQ-032 s0 sends 3-byte packet (last on byte 3) while s1 idle -> 3 transfers, release to IDLE, busy=0 next cycle, lsp=0.
REQ-033 G0 active, m_ready held low 10 cycles with s0_valid=1 and s1_valid=1 -> grant stays 01, m_data stable, s1_ready=0 throughout.
REQ-034 en dropped after byte 2 of 5-byte s1 packet -> bytes 3-5 still sent, then IDLE despite s0_valid=1; en=1 -> G0 next cycle.
REQ-035 rstn pulsed low during byte 4 of s0 burst -> grant=00 immediately (no clock), then with both valid first grant 01.
REQ-036 Random valid/last/m_ready, 10k cycles -> scoreboard per-source byte sequences match, no burst exceeds MAX_BURST, grant one-hot or zero.
